// File: rtl/lcd_fb_arbiter.sv
// Frame-memory arbiter: LCD display fetch has priority while DEN=1, queued pixel writes drain in blanking.
// Optional double buffering when FB_SWAP_EN is defined.
module lcd_fb_arbiter #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 24,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              DEN,
  input  logic              VD,
  input  logic [10:0]       Columna,
  input  logic [9:0]        Fila,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              wr_err,
  input  logic              swap_req,
  output logic              swap_done
);
  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int unsigned NPIX = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {S_IDLE, S_DISP, S_WR} state_t;
  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_fa [WFIFO_DEPTH];
  logic [DATA_W-1:0] r_fd [WFIFO_DEPTH];
  logic [PW:0]       r_count;
  logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
  logic              r_alive, r_wr_err;
  logic [ADDR_W:0]   r_hold;
  logic [1:0]        r_vld_pipe;
  logic [DATA_W-1:0] r_pix;

  logic              w_full, w_empty, w_push, w_pop, w_head_ok;
  logic              w_rd_msb, w_wr_msb, w_mem_we;
  logic [ADDR_W-1:0] w_disp_addr, w_head_addr;
  logic [ADDR_W:0]   w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_full      = (r_count == (PW+1)'(WFIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign wr_ready    = r_alive && !w_full;
  assign w_push      = wr_valid && wr_ready;
  assign w_head_addr = r_fa[r_rd_ptr];
  assign w_head_ok   = (32'(w_head_addr) < NPIX);
  assign w_disp_addr = ADDR_W'(Fila) * ADDR_W'(H_ACTIVE) + ADDR_W'(Columna);

  // Owner decision is combinational on DEN so the display never loses a cycle.
  always_comb begin
    w_next      = S_IDLE;
    w_pop       = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_hold;
    w_mem_wdata = '0;
    if (DEN) begin
      w_next     = S_DISP;
      w_mem_addr = {w_rd_msb, w_disp_addr};
    end else if (!w_empty) begin
      w_next = S_WR;
      w_pop  = 1'b1;
      if (w_head_ok) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = {w_wr_msb, w_head_addr};
        w_mem_wdata = r_fd[r_rd_ptr];
      end
    end
  end

  assign mem_we    = r_alive && w_mem_we;
  assign mem_addr  = r_alive ? w_mem_addr : '0;
  assign mem_wdata = r_alive ? w_mem_wdata : '0;
  assign pix_valid = r_vld_pipe[1];
  assign pix_data  = r_pix;
  assign wr_err    = r_wr_err;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_alive    <= 1'b0;
      r_wr_err   <= 1'b0;
      r_hold     <= '0;
      r_vld_pipe <= '0;
      r_pix      <= '0;
    end else begin
      r_alive    <= 1'b1;
      r_state    <= w_next;
      r_hold     <= mem_addr;
      r_count    <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_pop && !w_head_ok) r_wr_err <= 1'b1;
      r_vld_pipe <= {r_vld_pipe[0], DEN};
      // Read issued last cycle in DISP returns now; anything else blanks the pixel.
      r_pix      <= (r_state == S_DISP) ? mem_rdata : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fa[r_wr_ptr] <= wr_addr;
      r_fd[r_wr_ptr] <= wr_data;
    end
  end

`ifdef FB_SWAP_EN
  logic r_disp_sel, r_pend, r_vd_q, r_swap_done;
  logic w_vd_fall;

  assign w_vd_fall = r_vd_q && !VD;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_disp_sel  <= 1'b0;
      r_pend      <= 1'b0;
      r_vd_q      <= 1'b1;
      r_swap_done <= 1'b0;
    end else begin
      r_vd_q      <= VD;
      r_swap_done <= 1'b0;
      if (w_vd_fall && r_pend) begin
        r_disp_sel  <= !r_disp_sel;
        r_pend      <= swap_req;  // request on the edge itself waits a frame
        r_swap_done <= 1'b1;
      end else if (swap_req) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign w_rd_msb  = r_disp_sel;
  assign w_wr_msb  = !r_disp_sel;
  assign swap_done = r_swap_done;
`else
  logic w_unused_swap;
  assign w_unused_swap = swap_req ^ VD;
  assign w_rd_msb  = 1'b0;
  assign w_wr_msb  = 1'b0;
  assign swap_done = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Bench for lcd_fb_arbiter: directed scenarios plus a randomized run against a queue-based reference model.
module tb_lcd_fb_arbiter;
  localparam int H = 800, V = 480, AW = 19, DW = 24, D = 4;
  localparam int NPIX = H * V;
`ifdef FB_SWAP_EN
  localparam bit SWAP_BUILD = 1'b1;
`else
  localparam bit SWAP_BUILD = 1'b0;
`endif

  logic          CLK = 0, RST_n = 0, DEN = 0, VD = 1;
  logic [10:0]   Columna = 0;
  logic [9:0]    Fila = 0;
  logic          wr_valid = 0;
  logic [AW-1:0] wr_addr = 0;
  logic [DW-1:0] wr_data = 0;
  logic          wr_ready, mem_we, pix_valid, wr_err, swap_done;
  logic          swap_req = 0;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_wdata, pix_data;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0, failures = 0;
  bit sb_en = 0;

  always #5 CLK = ~CLK;

  lcd_fb_arbiter dut (
    .CLK(CLK), .RST_n(RST_n), .DEN(DEN), .VD(VD), .Columna(Columna), .Fila(Fila),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .wr_err(wr_err),
    .swap_req(swap_req), .swap_done(swap_done)
  );

  function automatic logic [DW-1:0] dflt(input int a);
    return DW'(a * 7 + 3) ^ 24'h5A5A5A;
  endfunction

  // Synchronous-read frame memory seen by the DUT.
  logic [DW-1:0] env_mem [int];
  always @(posedge CLK) begin
    if (mem_we) env_mem[int'(mem_addr)] = mem_wdata;
    mem_rdata <= env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : dflt(int'(mem_addr));
  end

  // Reference model: pending-write queue, frame contents, and a 2-cycle pixel delay.
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           q[$];
  logic [DW-1:0] ref_mem [int];
  bit            m_alive, m_err, p1v, p2v, m_pop, m_push;
  logic [DW-1:0] p1d, p2d;
  wr_t           m_h;
  int            m_da;

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      q.delete();
      m_alive = 0; m_err = 0; p1v = 0; p2v = 0; p1d = '0; p2d = '0;
    end else begin
      m_pop  = !DEN && q.size() > 0;
      m_push = wr_valid && m_alive && q.size() < D;
      p2v = p1v; p2d = p1d;
      p1v = DEN;
      if (DEN) begin
        m_da = int'(Fila) * H + int'(Columna);
        p1d  = ref_mem.exists(m_da) ? ref_mem[m_da] : dflt(m_da);
      end else p1d = '0;
      if (m_pop) begin
        m_h = q.pop_front();
        if (int'(m_h.a) >= NPIX) m_err = 1;
        else if (!SWAP_BUILD) ref_mem[int'(m_h.a)] = m_h.d;
      end
      if (m_push) q.push_back({wr_addr, wr_data});
      m_alive = 1;
    end
  end

  bit            e_rdy, e_we, e_chka;
  logic [AW:0]   e_addr;
  logic [DW-1:0] e_wd;
  always @(negedge CLK) begin
    if (sb_en && RST_n) begin
      e_rdy = m_alive && q.size() < D;
      e_we = 0; e_addr = '0; e_wd = '0; e_chka = 1;
      if (m_alive) begin
        e_chka = 0;
        if (DEN) begin
          e_addr = (AW+1)'(int'(Fila) * H + int'(Columna)); e_chka = 1;
        end else if (q.size() > 0 && int'(q[0].a) < NPIX) begin
          e_we = 1; e_addr = {SWAP_BUILD, q[0].a}; e_wd = q[0].d; e_chka = 1;
        end
      end
      checks++;
      if (wr_ready !== e_rdy) begin failures++; $display("FAIL sb_wr_ready t=%0t got=%0b exp=%0b", $time, wr_ready, e_rdy); end
      checks++;
      if (mem_we !== e_we) begin failures++; $display("FAIL sb_mem_we t=%0t got=%0b exp=%0b", $time, mem_we, e_we); end
      if (e_chka) begin
        checks++;
        if (mem_addr !== e_addr) begin failures++; $display("FAIL sb_mem_addr t=%0t got=%0h exp=%0h", $time, mem_addr, e_addr); end
      end
      if (e_we) begin
        checks++;
        if (mem_wdata !== e_wd) begin failures++; $display("FAIL sb_mem_wdata t=%0t got=%0h exp=%0h", $time, mem_wdata, e_wd); end
      end
      checks++;
      if (pix_valid !== p2v || pix_data !== p2d) begin
        failures++; $display("FAIL sb_pix t=%0t got=%0b/%0h exp=%0b/%0h", $time, pix_valid, pix_data, p2v, p2d);
      end
      checks++;
      if (wr_err !== m_err) begin failures++; $display("FAIL sb_wr_err t=%0t got=%0b exp=%0b", $time, wr_err, m_err); end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST_n = 0; DEN = 1; Fila = 1; Columna = 5;
    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, pix_valid, pix_data, wr_ready, wr_err, swap_done} !== '0) begin
      failures++; $display("FAIL reset_outputs we=%0b addr=%0h wd=%0h pv=%0b pd=%0h rdy=%0b err=%0b exp all 0",
                           mem_we, mem_addr, mem_wdata, pix_valid, pix_data, wr_ready, wr_err);
    end
    DEN = 0; RST_n = 1;
    tick();
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%0b exp=1", wr_ready); end
    tick();
  endtask

  task automatic test_display();
    bit dh[$];
    bit saw_we = 0;
    int base;
    dh.push_back(0); dh.push_back(0);
    for (int row = 0; row < 4; row++) begin
      base = (row == 1) ? 0 : int'($urandom_range(0, H - 8));
      for (int c = 0; c < 11; c++) begin
        DEN = (c < 8); Fila = 10'(row); Columna = 11'(base + c);
        dh.push_back(DEN);
        #3;
        if (mem_we) saw_we = 1;
        checks++;
        if (pix_valid !== dh[dh.size() - 3]) begin
          failures++; $display("FAIL disp_pix_valid row=%0d c=%0d got=%0b exp=%0b", row, c, pix_valid, dh[dh.size() - 3]);
        end
        if (row == 1 && c == 5) begin
          checks++;
          if (mem_addr !== 20'd805) begin failures++; $display("FAIL disp_addr_805 got=%0d exp=805", mem_addr); end
        end
        tick();
      end
    end
    checks++;
    if (saw_we) begin failures++; $display("FAIL disp_no_write got=1 exp=0"); end
  endtask

  task automatic test_fill_drain();
    DEN = 1; Fila = 2; wr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      Columna = 11'(100 + i); wr_addr = AW'(i); wr_data = 24'hAA0000 + DW'(i);
      #3;
      checks++;
      if (wr_ready !== 1'b1) begin failures++; $display("FAIL fill_ready i=%0d got=%0b exp=1", i, wr_ready); end
      tick();
    end
    wr_valid = 0;
    for (int k = 0; k < 4; k++) begin
      Columna = 11'(104 + k);
      #3;
      checks++;
      if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin
        failures++; $display("FAIL fill_full_hold k=%0d got rdy=%0b we=%0b exp 0/0", k, wr_ready, mem_we);
      end
      tick();
    end
    DEN = 0;
    for (int i = 0; i < 4; i++) begin
      #3;
      checks++;
      if (mem_we !== 1'b1 || mem_addr[AW-1:0] !== AW'(i) || mem_wdata !== 24'hAA0000 + DW'(i)) begin
        failures++; $display("FAIL drain_word i=%0d got we=%0b addr=%0h d=%0h exp 1/%0h/%0h",
                             i, mem_we, mem_addr, mem_wdata, i, 24'hAA0000 + i);
      end
      if (i > 0) begin
        checks++;
        if (wr_ready !== 1'b1) begin failures++; $display("FAIL drain_ready i=%0d got=%0b exp=1", i, wr_ready); end
      end
      tick();
    end
    #3;
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", mem_we); end
    tick();
  endtask

  task automatic test_preempt();
    logic [AW-1:0] ea [3];
    logic [DW-1:0] ed [3];
    DEN = 1; Fila = 3; Columna = 0; wr_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ea[i] = AW'($urandom_range(0, NPIX - 1)); ed[i] = DW'($urandom);
      wr_addr = ea[i]; wr_data = ed[i];
      tick();
    end
    wr_valid = 0; DEN = 0;
    #3;
    checks++;
    if (mem_we !== 1'b1 || mem_addr[AW-1:0] !== ea[0] || mem_wdata !== ed[0]) begin
      failures++; $display("FAIL preempt_first got we=%0b a=%0h d=%0h exp 1/%0h/%0h", mem_we, mem_addr, mem_wdata, ea[0], ed[0]);
    end
    tick();
    DEN = 1; Columna = 7;
    #3;
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 20'(3 * H + 7)) begin
      failures++; $display("FAIL preempt_switch got we=%0b a=%0d exp 0/%0d", mem_we, mem_addr, 3 * H + 7);
    end
    for (int k = 0; k < 5; k++) begin Columna = 11'(8 + k); tick(); end
    DEN = 0;
    for (int i = 1; i < 3; i++) begin
      #3;
      checks++;
      if (mem_we !== 1'b1 || mem_addr[AW-1:0] !== ea[i] || mem_wdata !== ed[i]) begin
        failures++; $display("FAIL preempt_rest i=%0d got we=%0b a=%0h d=%0h exp 1/%0h/%0h", i, mem_we, mem_addr, mem_wdata, ea[i], ed[i]);
      end
      tick();
    end
    #3;
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL preempt_empty got=%0b exp=0", mem_we); end
    tick();
  endtask

  task automatic test_oor();
    DEN = 0; wr_valid = 1; wr_addr = AW'(NPIX); wr_data = DW'($urandom);
    #3;
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL oor_accept got=%0b exp=1", wr_ready); end
    tick();
    wr_addr = AW'(5); wr_data = 24'h123456;
    #3;
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL oor_dropped got=%0b exp=0", mem_we); end
    tick();
    wr_valid = 0;
    #3;
    checks++;
    if (wr_err !== 1'b1 || mem_we !== 1'b1 || mem_addr[AW-1:0] !== AW'(5)) begin
      failures++; $display("FAIL oor_err_next got err=%0b we=%0b a=%0h exp 1/1/5", wr_err, mem_we, mem_addr);
    end
    for (int k = 0; k < 6; k++) begin DEN = k[0]; Fila = 10'(k); Columna = 11'(k); tick(); end
    DEN = 0;
    checks++;
    if (wr_err !== 1'b1) begin failures++; $display("FAIL oor_err_sticky got=%0b exp=1", wr_err); end
  endtask

  task automatic test_rst_mid();
    DEN = 1; Fila = 4; Columna = 10; wr_valid = 1;
    for (int i = 0; i < 3; i++) begin
      wr_addr = AW'(100 + i); wr_data = DW'($urandom); Columna = 11'(10 + i);
      tick();
    end
    wr_valid = 0;
    #2;
    RST_n = 0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, pix_valid, pix_data, wr_ready, wr_err} !== '0) begin
      failures++; $display("FAIL rst_mid_async we=%0b a=%0h pv=%0b pd=%0h rdy=%0b err=%0b exp all 0",
                           mem_we, mem_addr, pix_valid, pix_data, wr_ready, wr_err);
    end
    @(posedge CLK); #2;
    RST_n = 1; DEN = 0;
    tick();
    for (int k = 0; k < 6; k++) begin
      #3;
      checks++;
      if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin
        failures++; $display("FAIL rst_mid_no_stale k=%0d got we=%0b rdy=%0b exp 0/1", k, mem_we, wr_ready);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int run = 0;
    for (int n = 0; n < 3000; n++) begin
      if (run == 0) begin
        DEN = !DEN;
        run = DEN ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 6));
      end
      run--;
      Fila = 10'($urandom_range(0, V - 1)); Columna = 11'($urandom_range(0, H - 1));
      wr_valid = $urandom_range(0, 1) == 1;
      wr_addr = ($urandom_range(0, 15) == 0) ? AW'(NPIX + int'($urandom_range(0, 1000)))
                                             : AW'($urandom_range(0, NPIX - 1));
      wr_data = DW'($urandom);
      tick();
    end
    wr_valid = 0; DEN = 0;
    repeat (6) tick();
    #3;
    checks++;
    if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin
      failures++; $display("FAIL random_drained got we=%0b rdy=%0b exp 0/1", mem_we, wr_ready);
    end
    tick();
  endtask

`ifdef FB_SWAP_EN
  task automatic test_swap();
    sb_en = 0;
    DEN = 1; Fila = 0; Columna = 1;
    #3;
    checks++;
    if (mem_addr[AW] !== 1'b0) begin failures++; $display("FAIL swap_disp_msb_before got=%0b exp=0", mem_addr[AW]); end
    tick();
    DEN = 0; wr_valid = 1; wr_addr = AW'(20); wr_data = 24'h0000FF;
    tick();
    wr_valid = 0;
    #3;
    checks++;
    if (mem_we !== 1'b1 || mem_addr[AW] !== 1'b1) begin failures++; $display("FAIL swap_wr_msb_before got we=%0b msb=%0b exp 1/1", mem_we, mem_addr[AW]); end
    tick();
    swap_req = 1; tick(); swap_req = 0;
    repeat (3) tick();
    checks++;
    if (swap_done !== 1'b0) begin failures++; $display("FAIL swap_early got=%0b exp=0", swap_done); end
    VD = 0; tick();
    #3;
    checks++;
    if (swap_done !== 1'b1) begin failures++; $display("FAIL swap_done_pulse got=%0b exp=1", swap_done); end
    tick();
    checks++;
    if (swap_done !== 1'b0) begin failures++; $display("FAIL swap_done_width got=%0b exp=0", swap_done); end
    VD = 1; DEN = 1;
    #3;
    checks++;
    if (mem_addr[AW] !== 1'b1) begin failures++; $display("FAIL swap_disp_msb_after got=%0b exp=1", mem_addr[AW]); end
    tick();
    DEN = 0; wr_valid = 1; wr_addr = AW'(21);
    tick();
    wr_valid = 0;
    #3;
    checks++;
    if (mem_we !== 1'b1 || mem_addr[AW] !== 1'b0) begin failures++; $display("FAIL swap_wr_msb_after got we=%0b msb=%0b exp 1/0", mem_we, mem_addr[AW]); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    sb_en = 1;
    test_display();
    test_fill_drain();
    test_preempt();
    test_oor();
    test_rst_mid();
    test_random();
`ifdef FB_SWAP_EN
    test_swap();
`endif
    sb_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_fb_arbiter.md
Name: lcd_fb_arbiter

Overview:
Arbiter for the single-port pixel frame memory shared by the LCD display fetch path and a pixel write requester (drawing engine). It takes the DEN/Columna/Fila/VD timing from LCD_SYNC and gives the display path absolute priority during active video. Buffered writes drain only while DEN is low. It emits the fetched pixel with a fixed 2-cycle latency relative to the sync outputs.

Parameters:
H_ACTIVE, 800, active pixels per line
V_ACTIVE, 480, active lines per frame
ADDR_W, 19, frame address width (H_ACTIVE*V_ACTIVE must be <= 2**ADDR_W)
DATA_W, 24, pixel width (RGB888)
WFIFO_DEPTH, 4, write FIFO entries (power of two, >= 2)

Ports:
CLK  in  1  pixel clock, same clock as LCD_SYNC
RST_n  in  1  asynchronous active-low reset
DEN  in  1  data enable from LCD_SYNC
VD  in  1  vertical sync from LCD_SYNC (active low)
Columna  in  11  active-area column, valid when DEN=1
Fila  in  10  active-area row, valid when DEN=1
wr_valid  in  1  write request
wr_addr  in  ADDR_W  linear pixel address (Fila*H_ACTIVE+Columna)
wr_data  in  DATA_W  pixel to write
wr_ready  out  1  FIFO can accept
mem_addr  out  ADDR_W+1  memory address (MSB = buffer select)
mem_we  out  1  memory write strobe
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  synchronous-read data, 1-cycle latency
pix_data  out  DATA_W  pixel to panel
pix_valid  out  1  pix_data valid
wr_err  out  1  sticky: out-of-range write accepted
swap_req  in  1  request buffer swap (FB_SWAP_EN only)
swap_done  out  1  one-cycle pulse on swap (FB_SWAP_EN only)

Behaviour:
- Reset (async, RST_n=0): FIFO empty, state IDLE, all outputs 0, wr_ready=0 during reset and 1 from the first cycle after release.
- Write handshake: transfer when wr_valid&&wr_ready. wr_ready=!full (registered count). No data loss. Push and pop in the same cycle while full is not allowed: wr_ready reflects the count at the start of the cycle.
- Owner FSM, registered, evaluated each cycle:
  - DEN=1 -> DISP: mem_we=0, mem_addr=Fila*H_ACTIVE+Columna.
  - DEN=0 and FIFO not empty -> WR: pop head, mem_we=1, mem_addr/mem_wdata=head, one word per cycle.
  - Otherwise -> IDLE: mem_we=0, mem_addr holds.
- mem_* outputs are driven combinationally from the FSM decision made in the same cycle as DEN. DEN rising while the FIFO is non-empty causes an immediate switch to DISP. No write is split: a write occupies exactly one cycle.
- Display latency: DEN at cycle t -> read at t -> mem_rdata at t+1 -> pix_data/pix_valid registered at t+2. pix_valid = DEN delayed 2 cycles. pix_data=0 when pix_valid=0.
- Out-of-range write (wr_addr >= H_ACTIVE*V_ACTIVE): handshaked normally, dropped at pop (mem_we stays 0), wr_err set until reset.
- Full FIFO throughout a long DEN period: wr_ready=0 until the first blanking pop.
- Reset mid-frame: FIFO contents discarded. Outputs follow DEN normally from the first cycle after release.

Optional Feature:
FB_SWAP_EN
- Defined: double buffering. Register disp_sel (reset 0). Display reads use mem_addr MSB = disp_sel. Writes use MSB = !disp_sel. swap_req (level or pulse) sets pending. On VD falling edge with pending set: disp_sel toggles, pending clears, swap_done pulses 1 cycle. A swap_req arriving in the same cycle as that VD edge applies at the next frame. Swap does not flush the FIFO: entries already queued pop with the new !disp_sel.
- Undefined: single buffer. mem_addr MSB=0, swap_req ignored, swap_done tied 0.

Test Plan:
- Reset then free-run with LCD_SYNC, no writes -> pix_valid equals DEN delayed exactly 2 cycles. At Fila=1, Columna=5, mem_addr=805. mem_we never 1.
- Push 4 writes (addr 0..3, data 0xAA0000+i) during DEN=1 -> wr_ready=0 after 4th accept. No mem_we until DEN falls, then 4 consecutive mem_we cycles in order, wr_ready=1 after first pop.
- DEN rises with 2 FIFO entries pending after 1 popped -> mem_we=0 that cycle, remaining 2 pop after next DEN fall. Data and order preserved.
- Write to addr 384000 -> accepted, no mem_we for it, wr_err=1 and stays 1 until RST_n=0.
- Assert RST_n=0 mid-line with 3 entries queued -> outputs 0 asynchronously. After release, FIFO empty and no stale writes are issued.
- FB_SWAP_EN: pulse swap_req mid-frame -> on next VD falling edge swap_done=1 for 1 cycle. Display mem_addr MSB flips 0->1, write MSB flips 1->0.
